// File: rtl/program_memory_pkg.sv
// Shared types and constants for the loadable program memory.
// Holds the loader state encoding and the fetch classification helper.
package program_memory_pkg;

  localparam int unsigned DEF_INSTR_WIDTH = 21;
  localparam logic [DEF_INSTR_WIDTH-1:0] DEF_NOP_WORD = {16'b0, 5'b01111};
  localparam logic [DEF_INSTR_WIDTH-1:0] DEF_EOP_WORD = '1;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    FETCH_OUT_OF_RANGE,
    FETCH_PAST_END,
    FETCH_PROGRAM
  } fetch_kind_e;

  // Out-of-range takes priority over past-end, so a short DEPTH still flags.
  function automatic fetch_kind_e classify_fetch(input int unsigned addr,
                                                 input int unsigned prog_len,
                                                 input int unsigned depth);
    if (addr >= depth) return FETCH_OUT_OF_RANGE;
    if (addr >= prog_len) return FETCH_PAST_END;
    return FETCH_PROGRAM;
  endfunction

endpackage

// File: rtl/program_memory_loader.sv
// Load-port FSM: accepts words into the array, tracks write pointer and
// program length, and decides when the program becomes fetchable.
module program_memory_loader
  import program_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  output state_e                state,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   program_length,
  output logic                  wr_en_c,
  output logic [ADDR_WIDTH-1:0] wr_addr_c
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_d;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [ADDR_WIDTH:0]   len_d;
  logic                  done_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= EMPTY;
      ptr            <= '0;
      load_ready     <= 1'b0;
      load_done      <= 1'b0;
      program_length <= '0;
    end else begin
      state          <= state_d;
      ptr            <= ptr_d;
      load_ready     <= (state_d == LOAD);
      load_done      <= done_d;
      program_length <= len_d;
    end
  end

  // A restart always beats a word presented in the same cycle.
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    len_d     = program_length;
    done_d    = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = ptr;
    case (state)
      EMPTY: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          ptr_d = '0;
        end else if (load_valid && load_ready) begin
          wr_en_c = 1'b1;
          if (load_last || (ptr == LAST_PTR)) begin
            state_d = RUN;
            len_d   = (ADDR_WIDTH + 1)'(ptr) + (ADDR_WIDTH + 1)'(1);
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr + ADDR_WIDTH'(1);
          end
        end
      end
      RUN: begin
        if (load_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          len_d   = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/program_memory.sv
// Run-time loadable instruction store with a registered single-cycle fetch
// port; fetches are masked to NOP until a program has been loaded.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int unsigned            INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned            ADDR_WIDTH  = 8,
  parameter int unsigned            DEPTH       = 256,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = INSTR_WIDTH'(DEF_NOP_WORD),
  parameter logic [INSTR_WIDTH-1:0] EOP_WORD    = '1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   suspend_cpu,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic                   load_last,
  input  logic [INSTR_WIDTH-1:0] load_data,
  output logic                   load_ready,
  output logic                   load_done,
  input  logic [ADDR_WIDTH-1:0]  instruction_memory_address,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instruction_valid,
  output logic                   instruction_memory_address_exceeded,
  output logic                   instruction_end_of_program,
  output logic [ADDR_WIDTH:0]    program_length
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                 state;
  logic                   wr_en_c;
  logic [ADDR_WIDTH-1:0]  wr_addr_c;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  fetch_kind_e            kind;
  logic [IDX_W-1:0]       rd_idx;
  logic [INSTR_WIDTH-1:0] rd_word;
  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   valid_d;
  logic                   exceeded_d;
  logic                   eop_d;

  program_memory_loader #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_loader (
    .clk            (clk),
    .rstn           (rstn),
    .load_start     (load_start),
    .load_valid     (load_valid),
    .load_last      (load_last),
    .state          (state),
    .load_ready     (load_ready),
    .load_done      (load_done),
    .program_length (program_length),
    .wr_en_c        (wr_en_c),
    .wr_addr_c      (wr_addr_c)
  );

  // Array contents survive reset; program_length alone decides visibility.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[IDX_W'(wr_addr_c)] <= load_data;
  end

  always_comb begin
    kind    = classify_fetch(32'(instruction_memory_address), 32'(program_length), DEPTH);
    rd_idx  = (kind == FETCH_OUT_OF_RANGE) ? '0 : IDX_W'(instruction_memory_address);
    rd_word = mem[rd_idx];
  end

  always_comb begin
    instr_d    = NOP_WORD;
    valid_d    = 1'b0;
    exceeded_d = 1'b0;
    eop_d      = 1'b0;
    if (state == RUN) begin
      case (kind)
        FETCH_OUT_OF_RANGE: exceeded_d = 1'b1;
        FETCH_PAST_END: begin
          instr_d = EOP_WORD;
          valid_d = 1'b1;
          eop_d   = 1'b1;
        end
        default: begin
          instr_d = rd_word;
          valid_d = 1'b1;
          eop_d   = (rd_word == EOP_WORD);
        end
      endcase
    end
  end

  // Suspend freezes the fetch outputs only; the load path keeps running.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instruction                         <= NOP_WORD;
      instruction_valid                   <= 1'b0;
      instruction_memory_address_exceeded <= 1'b0;
      instruction_end_of_program          <= 1'b0;
    end else if (!suspend_cpu) begin
      instruction                         <= instr_d;
      instruction_valid                   <= valid_d;
      instruction_memory_address_exceeded <= exceeded_d;
      instruction_end_of_program          <= eop_d;
    end
  end

endmodule

// File: tb/tb_program_memory.sv
// Directed bench for program_memory (DEPTH=200) with a fetch scoreboard
// fed from a behavioural model of the loaded program.
module tb_program_memory;

  localparam int unsigned IW    = 21;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam logic [IW-1:0] NOP = 21'h0000F;
  localparam logic [IW-1:0] EOP = 21'h1FFFFF;

  logic          clk;
  logic          rstn;
  logic          suspend_cpu;
  logic          load_start;
  logic          load_valid;
  logic          load_last;
  logic [IW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic [AW-1:0] instruction_memory_address;
  logic [IW-1:0] instruction;
  logic          instruction_valid;
  logic          instruction_memory_address_exceeded;
  logic          instruction_end_of_program;
  logic [AW:0]   program_length;

  program_memory #(
    .INSTR_WIDTH (IW),
    .ADDR_WIDTH  (AW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk                                 (clk),
    .rstn                                (rstn),
    .suspend_cpu                         (suspend_cpu),
    .load_start                          (load_start),
    .load_valid                          (load_valid),
    .load_last                           (load_last),
    .load_data                           (load_data),
    .load_ready                          (load_ready),
    .load_done                           (load_done),
    .instruction_memory_address          (instruction_memory_address),
    .instruction                         (instruction),
    .instruction_valid                   (instruction_valid),
    .instruction_memory_address_exceeded (instruction_memory_address_exceeded),
    .instruction_end_of_program          (instruction_end_of_program),
    .program_length                      (program_length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic          valid;
    logic          exc;
    logic          eop;
  } exp_t;

  exp_t          sb[$];
  exp_t          held;
  logic [IW-1:0] model_mem [DEPTH];
  int unsigned   model_len;
  int unsigned   model_ptr;
  bit            model_run;
  int            n_checks;
  int            n_errors;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t calc(input int unsigned a);
    exp_t e;
    e = '{instr: NOP, valid: 1'b0, exc: 1'b0, eop: 1'b0};
    if (model_run) begin
      if (a >= DEPTH) begin
        e.exc = 1'b1;
      end else if (a >= model_len) begin
        e = '{instr: EOP, valid: 1'b1, exc: 1'b0, eop: 1'b1};
      end else begin
        e = '{instr: model_mem[a], valid: 1'b1, exc: 1'b0, eop: (model_mem[a] == EOP)};
      end
    end
    return e;
  endfunction

  task automatic fetch_step(input int unsigned a, input bit susp, input string tag);
    exp_t e;
    instruction_memory_address = AW'(a);
    suspend_cpu = susp;
    if (!susp) held = calc(a);
    sb.push_back(held);
    tick();
    e = sb.pop_front();
    check({tag, " instr"}, 32'(instruction), 32'(e.instr));
    check({tag, " valid"}, 32'(instruction_valid), 32'(e.valid));
    check({tag, " exceeded"}, 32'(instruction_memory_address_exceeded), 32'(e.exc));
    check({tag, " eop"}, 32'(instruction_end_of_program), 32'(e.eop));
  endtask

  task automatic start_load(input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_run = 1'b0;
    model_len = 0;
    model_ptr = 0;
    held = '{instr: NOP, valid: 1'b0, exc: 1'b0, eop: 1'b0};
    check({tag, " load_ready"}, 32'(load_ready), 32'd1);
    check({tag, " length cleared"}, 32'(program_length), 32'd0);
  endtask

  task automatic send(input logic [IW-1:0] data, input bit last, input string tag);
    bit ends;
    ends = last || (model_ptr == DEPTH - 1);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    model_mem[model_ptr] = data;
    if (ends) begin
      model_len = model_ptr + 1;
      model_run = 1'b1;
      check({tag, " load_done"}, 32'(load_done), 32'd1);
      check({tag, " program_length"}, 32'(program_length), 32'(model_len));
      check({tag, " ready after done"}, 32'(load_ready), 32'd0);
    end else begin
      model_ptr++;
      check({tag, " load_done low"}, 32'(load_done), 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_run = 1'b0;
    model_len = 0;
    model_ptr = 0;
    held = '{instr: NOP, valid: 1'b0, exc: 1'b0, eop: 1'b0};
    rstn = 1'b0;
    suspend_cpu = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_data = '0;
    instruction_memory_address = '0;

    // Reset values
    tick();
    tick();
    check("rst instr", 32'(instruction), 32'(NOP));
    check("rst valid", 32'(instruction_valid), 32'd0);
    check("rst exceeded", 32'(instruction_memory_address_exceeded), 32'd0);
    check("rst eop", 32'(instruction_end_of_program), 32'd0);
    check("rst load_ready", 32'(load_ready), 32'd0);
    check("rst load_done", 32'(load_done), 32'd0);
    check("rst length", 32'(program_length), 32'd0);
    rstn = 1'b1;
    fetch_step(5, 1'b0, "empty fetch5");

    // Basic four-word program
    start_load("load4");
    for (int i = 0; i < 4; i++) send(IW'(i + 1), i == 3, "load4");
    for (int a = 0; a < 5; a++) fetch_step(a, 1'b0, "run4 fetch");
    check("load_done one cycle", 32'(load_done), 32'd0);

    // Address range boundaries
    fetch_step(210, 1'b0, "fetch210");
    fetch_step(199, 1'b0, "fetch199");
    fetch_step(200, 1'b0, "fetch200");

    // Suspend holds the registered fetch
    fetch_step(1, 1'b0, "pre-suspend");
    fetch_step(2, 1'b1, "suspend a");
    fetch_step(2, 1'b1, "suspend b");
    fetch_step(2, 1'b0, "released");

    // Partial load, restart, collision restart, short program
    start_load("reload");
    for (int i = 0; i < 3; i++) send(IW'(32'h100 + i), 1'b0, "partial3");
    start_load("restart1");
    send(21'h200, 1'b0, "partial1");
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 21'h1ABCD;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    model_ptr = 0;
    check("collision ready", 32'(load_ready), 32'd1);
    check("collision done", 32'(load_done), 32'd0);
    send(21'h300, 1'b0, "final2");
    send(21'h301, 1'b1, "final2");
    for (int a = 0; a < 3; a++) fetch_step(a, 1'b0, "run2 fetch");

    // Fill to DEPTH without load_last; word 50 equals the EOP pattern
    start_load("fill");
    for (int i = 0; i < int'(DEPTH); i++)
      send((i == 50) ? EOP : IW'(i * 3 + 7), 1'b0, "fill");
    fetch_step(0, 1'b0, "full fetch0");
    fetch_step(50, 1'b0, "full fetch50");
    fetch_step(120, 1'b0, "full fetch120");
    fetch_step(199, 1'b0, "full fetch199");

    // Reset in the middle of a load
    start_load("midload");
    for (int i = 0; i < 5; i++) send(IW'(32'h40 + i), 1'b0, "midload");
    load_valid = 1'b1;
    load_data  = 21'h55;
    rstn = 1'b0;
    tick();
    load_valid = 1'b0;
    model_run = 1'b0;
    model_len = 0;
    held = '{instr: NOP, valid: 1'b0, exc: 1'b0, eop: 1'b0};
    check("midrst load_ready", 32'(load_ready), 32'd0);
    check("midrst load_done", 32'(load_done), 32'd0);
    check("midrst length", 32'(program_length), 32'd0);
    check("midrst instr", 32'(instruction), 32'(NOP));
    check("midrst valid", 32'(instruction_valid), 32'd0);
    rstn = 1'b1;
    fetch_step(0, 1'b0, "post-rst fetch0");
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
